// File: rtl/xc_malu_divrem.sv
// Iterative 32-bit signed/unsigned divide/remainder, restoring algorithm, one bit per cycle.
// Fixed 33-cycle latency regardless of operands; flush or valid drop returns to IDLE.
module xc_malu_divrem (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  input  logic        valid,
  input  logic        uop_div,
  input  logic        uop_divu,
  input  logic        uop_rem,
  input  logic        uop_remu,
  output logic [63:0] result,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  counter;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] divisor;
  logic        neg_q;
  logic        neg_r;
  logic        is_rem;
  logic        div_zero;

  logic        any_uop;
  logic        start;
  logic        sel_signed;
  logic        sel_rem;
  logic [31:0] rs1_abs;
  logic [31:0] rs2_abs;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        no_borrow;

  // Priority div > divu > rem > remu resolved into a signedness and a rem/div select.
  assign any_uop    = uop_div | uop_divu | uop_rem | uop_remu;
  assign start      = valid & ~flush & any_uop;
  assign sel_signed = uop_div | (~uop_divu & uop_rem);
  assign sel_rem    = ~uop_div & ~uop_divu & (uop_rem | uop_remu);
  assign rs1_abs    = (sel_signed && rs1[31]) ? (32'd0 - rs1) : rs1;
  assign rs2_abs    = (sel_signed && rs2[31]) ? (32'd0 - rs2) : rs2;

  assign shifted    = {rem, quot[31]};
  assign diff       = {1'b0, shifted} - {2'b00, divisor};
  assign no_borrow  = ~diff[33];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nxt = CALC;
        CALC: begin
          if (!valid)               state_nxt = IDLE;
          else if (counter == 5'd31) state_nxt = FIX;
        end
        FIX:  state_nxt = valid ? DONE : IDLE;
        DONE: if (!valid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      counter  <= 5'd0;
      quot     <= 32'd0;
      rem      <= 32'd0;
      divisor  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_rem   <= 1'b0;
      div_zero <= 1'b0;
      result   <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            quot     <= rs1_abs;
            divisor  <= rs2_abs;
            rem      <= 32'd0;
            counter  <= 5'd0;
            neg_q    <= sel_signed & (rs1[31] ^ rs2[31]);
            neg_r    <= sel_signed & rs1[31];
            is_rem   <= sel_rem;
            div_zero <= (rs2 == 32'd0);
          end
        end
        CALC: begin
          // quot doubles as the dividend shift register; quotient bits enter at the LSB.
          rem     <= no_borrow ? diff[31:0] : shifted[31:0];
          quot    <= {quot[30:0], no_borrow};
          counter <= counter + 5'd1;
        end
        FIX: begin
          // A zero divisor leaves an all-ones unsigned quotient that must not be negated.
          if (valid && !flush) begin
            if (is_rem)
              result <= {32'd0, neg_r ? (32'd0 - rem) : rem};
            else
              result <= {32'd0, (neg_q && !div_zero) ? (32'd0 - quot) : quot};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_divrem.sv
// Randomized check of xc_malu_divrem against an arithmetic reference, plus directed corner cases.
module tb_xc_malu_divrem;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] rs1, rs2;
  logic        flush, valid;
  logic        uop_div, uop_divu, uop_rem, uop_remu;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] U_DIV  = 4'b1000;
  localparam logic [3:0] U_DIVU = 4'b0100;
  localparam logic [3:0] U_REM  = 4'b0010;
  localparam logic [3:0] U_REMU = 4'b0001;

  xc_malu_divrem dut (
    .clock    (clock),
    .resetn   (resetn),
    .rs1      (rs1),
    .rs2      (rs2),
    .flush    (flush),
    .valid    (valid),
    .uop_div  (uop_div),
    .uop_divu (uop_divu),
    .uop_rem  (uop_rem),
    .uop_remu (uop_remu),
    .result   (result),
    .ready    (ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V style div/rem semantics, highest-priority uop wins.
  function automatic logic [63:0] ref_res(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (u[3]) begin
      if (b == 0)                                   r = 32'hFFFFFFFF;
      else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
      else                                          r = sa / sb;
    end else if (u[2]) begin
      r = (b == 0) ? 32'hFFFFFFFF : a / b;
    end else if (u[1]) begin
      if (b == 0)                                   r = a;
      else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
      else                                          r = sa % sb;
    end else begin
      r = (b == 0) ? a : a % b;
    end
    return {32'd0, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 15);
      4: return 32'd0 - $urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b);
    {uop_div, uop_divu, uop_rem, uop_remu} = u;
    rs1   = a;
    rs2   = b;
    valid = 1'b1;
  endtask

  // Counts edges until ready, starting from the current point; bounded.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < 80) begin
      tick();
      lat++;
    end
  endtask

  task automatic ack();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    chk("ready_after_flush", {63'd0, ready}, 64'd0);
  endtask

  // Full request: the first edge samples valid, then ready must follow 33 edges later.
  task automatic run_op(input string tag, input logic [3:0] u, input logic [31:0] a, input logic [31:0] b);
    int lat;
    set_req(u, a, b);
    tick();
    wait_ready(lat);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_res"}, result, ref_res(u, a, b));
    ack();
  endtask

  initial begin
    int lat;
    logic [63:0] first_res;
    resetn = 1'b0; flush = 1'b0; valid = 1'b0;
    rs1 = '0; rs2 = '0;
    {uop_div, uop_divu, uop_rem, uop_remu} = 4'b0;
    repeat (2) tick();
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    resetn = 1'b1;
    tick();

    run_op("div_m7_2", U_DIV, 32'hFFFFFFF9, 32'd2);
    chk("div_m7_2_const", result, 64'h00000000_FFFFFFFD);
    run_op("rem_m7_2", U_REM, 32'hFFFFFFF9, 32'd2);
    chk("rem_m7_2_const", result, 64'h00000000_FFFFFFFF);
    run_op("divu_z", U_DIVU, 32'h12345678, 32'd0);
    chk("divu_z_const", result, 64'h00000000_FFFFFFFF);
    run_op("remu_z", U_REMU, 32'h12345678, 32'd0);
    chk("remu_z_const", result, 64'h00000000_12345678);
    run_op("div_z", U_DIV, 32'hFFFFFFF9, 32'd0);
    run_op("rem_z", U_REM, 32'hFFFFFFF9, 32'd0);
    run_op("div_ovf", U_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_const", result, 64'h00000000_80000000);
    run_op("rem_ovf", U_REM, 32'h80000000, 32'hFFFFFFFF);
    chk("rem_ovf_const", result, 64'd0);
    run_op("divu_ovf", U_DIVU, 32'h80000000, 32'hFFFFFFFF);
    chk("divu_ovf_const", result, 64'd0);
    run_op("remu_ovf", U_REMU, 32'h80000000, 32'hFFFFFFFF);
    chk("remu_ovf_const", result, 64'h00000000_80000000);

    // Back-to-back: flush on the ready cycle with valid held and new operands presented.
    set_req(U_DIVU, 32'd100, 32'd7);
    tick();
    wait_ready(lat);
    chk("b2b_first", result, 64'd14);
    set_req(U_REMU, 32'd100, 32'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("b2b_flush_ready", {63'd0, ready}, 64'd0);
    wait_ready(lat);
    chk("b2b_lat", 64'(lat), 64'd34);
    chk("b2b_second", result, 64'd2);
    ack();

    // Abort in CALC by dropping valid after ten steps.
    set_req(U_DIV, 32'd1000, 32'd3);
    tick();
    repeat (10) tick();
    valid = 1'b0;
    tick();
    chk("abort_ready", {63'd0, ready}, 64'd0);
    lat = 0;
    repeat (40) begin
      tick();
      if (ready) lat++;
    end
    chk("abort_stays_idle", 64'(lat), 64'd0);
    run_op("after_abort", U_DIV, 32'd1000, 32'hFFFFFFFD);

    // No uop set: valid alone must never raise ready.
    set_req(4'b0000, 32'd9, 32'd3);
    lat = 0;
    repeat (40) begin
      tick();
      if (ready) lat++;
    end
    chk("no_uop", 64'(lat), 64'd0);
    valid = 1'b0;
    tick();

    // Synchronous reset mid-CALC clears ready and result.
    set_req(U_DIVU, 32'd55, 32'd5);
    tick();
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    chk("midreset_ready", {63'd0, ready}, 64'd0);
    chk("midreset_result", result, 64'd0);
    resetn = 1'b1;
    valid  = 1'b0;
    tick();
    run_op("after_reset", U_DIVU, 32'd55, 32'd5);

    // Random regression; multi-bit uop vectors exercise priority too.
    for (int i = 0; i < 1200; i++) begin
      logic [3:0] u;
      u = 4'($urandom_range(1, 15));
      run_op("rand", u, pick(), pick());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
